// File: rtl/cdt_pkg.sv
// cdt_pkg: shared state/field encodings, button decode and defaults for the countdown sequencer.
package cdt_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    ALARM = 3'd4
  } state_e;
  typedef enum logic [1:0] {
    SEC = 2'd0,
    MIN = 2'd1,
    HR  = 2'd2
  } field_e;
  typedef enum logic [2:0] {
    BTN_NONE,
    BTN_CLR,
    BTN_START,
    BTN_MODE,
    BTN_INC
  } btn_e;
  localparam int TICK_DIV_DEF   = 50_000_000;
  localparam int ALARM_SECS_DEF = 10;
  // Only the highest-priority pulse survives a cycle: clr > start > mode > inc.
  function automatic btn_e pick_btn(input logic c, input logic s, input logic m, input logic i);
    return c ? BTN_CLR : s ? BTN_START : m ? BTN_MODE : i ? BTN_INC : BTN_NONE;
  endfunction
endpackage

// File: rtl/cdt_tick_gen.sv
// cdt_tick_gen: enable/clear divider producing a one-cycle tick per TICK_DIV cycles.
// With CDT_BLINK_EN it also emits a half pulse every TICK_DIV/2 cycles.
module cdt_tick_gen #(
  parameter int TICK_DIV = 50_000_000,
  parameter int TW       = $clog2(TICK_DIV)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
`ifdef CDT_BLINK_EN
  ,
  output logic half
`endif
);
  localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);
  logic [TW-1:0] cnt_q, cnt_d;
  assign tick = en && cnt_q == LAST;
`ifdef CDT_BLINK_EN
  assign half = en && (cnt_q == LAST || cnt_q == TW'(TICK_DIV / 2 - 1));
`endif
  always_comb cnt_d = clr ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + TW'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/countdown_sequencer.sv
// countdown_sequencer: button-to-strobe control FSM and 1 Hz time base for the countdown datapath.
// Optional CDT_BLINK_EN adds a 1 Hz display blink in SET and PAUSE.
module countdown_sequencer
  import cdt_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int ALARM_SECS = ALARM_SECS_DEF,
  parameter int TW         = $clog2(TICK_DIV)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_clr,
  input  logic       time_zero,
  output logic       dec_en,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       inc_hr,
  output logic       clr,
  output logic       alarm,
  output logic [2:0] state,
  output logic [1:0] field,
  output logic       blink
);
  state_e state_q, state_d;
  field_e field_q, field_d;
  logic [7:0] acnt_q, acnt_d;
  logic dec_q, dec_d, isec_q, isec_d, imin_q, imin_d, ihr_q, ihr_d, clr_q, clr_d, alarm_q;
  logic tick, div_en, div_clr;
  btn_e btn;
  assign btn = pick_btn(btn_clr, btn_start, btn_mode, btn_inc);
  assign div_en = state_q == RUN || state_q == ALARM;
  // A fresh second starts on RUN entry from IDLE/SET and on ALARM entry; resume from PAUSE keeps the count.
  assign div_clr = (state_d == RUN && (state_q == IDLE || state_q == SET)) ||
                   (state_d == ALARM && state_q != ALARM);
`ifdef CDT_BLINK_EN
  logic div_half;
`endif
  cdt_tick_gen #(.TICK_DIV(TICK_DIV), .TW(TW)) u_div (
    .clk (clk),
    .rst (reset),
    .en  (div_en),
    .clr (div_clr),
    .tick(tick)
`ifdef CDT_BLINK_EN
    ,
    .half(div_half)
`endif
  );
  always_comb begin
    state_d = state_q;
    field_d = field_q;
    acnt_d  = acnt_q;
    dec_d   = 1'b0;
    isec_d  = 1'b0;
    imin_d  = 1'b0;
    ihr_d   = 1'b0;
    clr_d   = 1'b0;
    unique case (state_q)
      IDLE:
        if (btn == BTN_CLR) clr_d = 1'b1;
        else if (btn == BTN_START && !time_zero) state_d = RUN;
        else if (btn == BTN_MODE) begin
          state_d = SET;
          field_d = SEC;
        end
      SET:
        if (btn == BTN_CLR) clr_d = 1'b1;
        else if (btn == BTN_START && !time_zero) state_d = RUN;
        else if (btn == BTN_MODE) begin
          state_d = field_q == HR ? IDLE : SET;
          field_d = field_q == SEC ? MIN : field_q == MIN ? HR : SEC;
        end else if (btn == BTN_INC) begin
          isec_d = field_q == SEC;
          imin_d = field_q == MIN;
          ihr_d  = field_q == HR;
        end
      RUN:
        if (time_zero) state_d = ALARM;
        else begin
          dec_d = tick && btn != BTN_CLR;
          if (btn == BTN_CLR) begin
            clr_d   = 1'b1;
            state_d = IDLE;
          end else if (btn == BTN_START) state_d = PAUSE;
        end
      PAUSE:
        if (btn == BTN_CLR) begin
          clr_d   = 1'b1;
          state_d = IDLE;
        end else if (btn == BTN_START) state_d = RUN;
      ALARM:
        if (btn != BTN_NONE || (tick && acnt_q == 8'(ALARM_SECS - 1))) begin
          state_d = IDLE;
          acnt_d  = '0;
        end else if (tick) acnt_d = acnt_q + 8'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      field_q <= SEC;
      acnt_q  <= '0;
      dec_q   <= 1'b0;
      isec_q  <= 1'b0;
      imin_q  <= 1'b0;
      ihr_q   <= 1'b0;
      clr_q   <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      acnt_q  <= acnt_d;
      dec_q   <= dec_d;
      isec_q  <= isec_d;
      imin_q  <= imin_d;
      ihr_q   <= ihr_d;
      clr_q   <= clr_d;
      alarm_q <= state_d == ALARM;
    end
  assign dec_en  = dec_q;
  assign inc_sec = isec_q;
  assign inc_min = imin_q;
  assign inc_hr  = ihr_q;
  assign clr     = clr_q;
  assign alarm   = alarm_q;
  assign state   = state_q;
  assign field   = field_q;
`ifdef CDT_BLINK_EN
  logic ph_en, ph_clr, ph_tick, ph_half, blink_q, blink_d;
  assign ph_en  = state_q == SET || state_q == PAUSE;
  assign ph_clr = state_d == SET && state_q != SET;
  cdt_tick_gen #(.TICK_DIV(TICK_DIV), .TW(TW)) u_phase (
    .clk (clk),
    .rst (reset),
    .en  (ph_en),
    .clr (ph_clr),
    .tick(ph_tick),
    .half(ph_half)
  );
  always_comb blink_d = (state_d == SET || state_d == PAUSE) ? blink_q ^ (ph_half | div_half) : 1'b0;
  always_ff @(posedge clk or posedge reset)
    if (reset) blink_q <= 1'b0;
    else blink_q <= blink_d;
  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif
endmodule

// File: tb/tb_countdown_sequencer.sv
// tb_countdown_sequencer: directed plus random stimulus checked every cycle against a behavioural watch model.
module tb_countdown_sequencer;
  localparam int TD = 8;
  localparam int AS = 3;
  logic clk = 1'b0, reset = 1'b0;
  logic btn_start = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0, btn_clr = 1'b0, time_zero = 1'b1;
  logic dec_en, inc_sec, inc_min, inc_hr, clr, alarm, blink;
  logic [2:0] state;
  logic [1:0] field;
  countdown_sequencer #(.TICK_DIV(TD), .ALARM_SECS(AS)) dut (
    .clk(clk), .reset(reset), .btn_start(btn_start), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .btn_clr(btn_clr), .time_zero(time_zero), .dec_en(dec_en), .inc_sec(inc_sec), .inc_min(inc_min),
    .inc_hr(inc_hr), .clr(clr), .alarm(alarm), .state(state), .field(field), .blink(blink)
  );
  always #5 clk = ~clk;
  int n_vec = 0, n_err = 0;
  int m_mode = 0, m_fld = 0, m_sub = 0, m_acyc = 0;
  bit e_dec = 0, e_isec = 0, e_imin = 0, e_ihr = 0, e_clr = 0;
  int dp_h = 0, dp_m = 0, dp_s = 0;
  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit dp_zero();
    return dp_h == 0 && dp_m == 0 && dp_s == 0;
  endfunction
  task automatic dp_update();
    if (e_clr) begin dp_h = 0; dp_m = 0; dp_s = 0; end
    else if (e_isec) dp_s = (dp_s + 1) % 60;
    else if (e_imin) dp_m = (dp_m + 1) % 60;
    else if (e_ihr) dp_h = (dp_h + 1) % 24;
    else if (e_dec) begin
      if (dp_s > 0) dp_s--;
      else if (dp_m > 0) begin dp_m--; dp_s = 59; end
      else if (dp_h > 0) begin dp_h--; dp_m = 59; dp_s = 59; end
    end
  endtask
  task automatic model_reset();
    m_mode = 0; m_fld = 0; m_sub = 0; m_acyc = 0;
    e_dec = 0; e_isec = 0; e_imin = 0; e_ihr = 0; e_clr = 0;
  endtask
  task automatic model_step(input bit c, input bit s, input bit m, input bit i, input bit tz);
    int top;
    bit running, tick;
    top = c ? 1 : s ? 2 : m ? 3 : i ? 4 : 0;
    running = m_mode == 2 || m_mode == 4;
    tick = running && m_sub == TD - 1;
    if (running) m_sub = (m_sub + 1) % TD;
    e_dec = 0; e_isec = 0; e_imin = 0; e_ihr = 0; e_clr = 0;
    case (m_mode)
      0: if (top == 1) e_clr = 1;
         else if (top == 2 && !tz) begin m_mode = 2; m_sub = 0; end
         else if (top == 3) begin m_mode = 1; m_fld = 0; end
      1: if (top == 1) e_clr = 1;
         else if (top == 2 && !tz) begin m_mode = 2; m_sub = 0; end
         else if (top == 3) begin
           if (m_fld == 2) begin m_mode = 0; m_fld = 0; end
           else m_fld++;
         end else if (top == 4) begin
           e_isec = m_fld == 0; e_imin = m_fld == 1; e_ihr = m_fld == 2;
         end
      2: if (tz) begin m_mode = 4; m_sub = 0; m_acyc = 0; end
         else begin
           e_dec = tick && top != 1;
           if (top == 1) begin e_clr = 1; m_mode = 0; end
           else if (top == 2) m_mode = 3;
         end
      3: if (top == 1) begin e_clr = 1; m_mode = 0; end
         else if (top == 2) m_mode = 2;
      default: begin
        m_acyc++;
        if (top != 0 || m_acyc == AS * TD) m_mode = 0;
      end
    endcase
  endtask
  task automatic check_all();
    chk("state", int'(state), m_mode);
    chk("field", int'(field), m_fld);
    chk("strobes", int'({dec_en, inc_sec, inc_min, inc_hr, clr}), int'({e_dec, e_isec, e_imin, e_ihr, e_clr}));
    chk("alarm", int'(alarm), int'(m_mode == 4));
`ifndef CDT_BLINK_EN
    chk("blink", int'(blink), 0);
`endif
  endtask
  task automatic cyc(input bit c, input bit s, input bit m, input bit i);
    bit tz;
    btn_clr = c; btn_start = s; btn_mode = m; btn_inc = i;
    @(posedge clk);
    tz = time_zero;
    dp_update();
    model_step(c, s, m, i, tz);
    #1;
    check_all();
    btn_clr = 0; btn_start = 0; btn_mode = 0; btn_inc = 0;
    time_zero = dp_zero();
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0);
  endtask
  task automatic set_secs(input int n);
    cyc(0, 0, 1, 0);
    repeat (n) cyc(0, 0, 0, 1);
    repeat (3) cyc(0, 0, 1, 0);
  endtask
  task automatic wait_alarm(input int bound);
    for (int k = 0; k < bound && !alarm; k++) idle(1);
    chk("alarm_rise", int'(alarm), 1);
  endtask
  task automatic async_reset();
    #2 reset = 1;
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_alarm", int'(alarm), 0);
    chk("rst_field", int'(field), 0);
    chk("rst_strobes", int'({dec_en, inc_sec, inc_min, inc_hr, clr}), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    int g, a;
    bit rc, rs, rm, ri;
    #1 reset = 1;
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_alarm", int'(alarm), 0);
    chk("rst_blink", int'(blink), 0);
    @(negedge clk) reset = 0;
    cyc(0, 0, 1, 0); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 1, 0); cyc(0, 0, 0, 1); idle(1);
    chk("set_field", int'(field), 1);
    chk("set_state", int'(state), 1);
    cyc(1, 0, 0, 0);
    chk("set_clr_field", int'(field), 1);
    idle(1);
    cyc(0, 1, 0, 0);
    chk("zero_start_set", int'(state), 1);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    chk("back_idle", int'(state), 0);
    cyc(0, 1, 0, 0);
    chk("zero_start_idle", int'(state), 0);
    set_secs(3);
    cyc(0, 1, 0, 0);
    idle(10);
    cyc(0, 1, 0, 0);
    chk("paused", int'(state), 3);
    idle(5);
    cyc(0, 1, 0, 0);
    g = 0;
    for (int k = 1; k <= TD + 2 && g == 0; k++) begin
      idle(1);
      if (dec_en) g = k;
    end
    chk("resume_gap", g, 5);
    wait_alarm(40);
    a = 0;
    while (alarm && a < 100) begin idle(1); a++; end
    chk("alarm_len", a, AS * TD);
    set_secs(2);
    cyc(0, 1, 0, 0);
    idle(3);
    cyc(1, 1, 0, 0);
    chk("sim_clr", int'(clr), 1);
    chk("sim_state", int'(state), 0);
    idle(1);
    chk("sim_clr_once", int'(clr), 0);
    set_secs(1);
    cyc(0, 1, 0, 0);
    wait_alarm(20);
    idle(4);
    async_reset();
    set_secs(1);
    cyc(0, 1, 0, 0);
    wait_alarm(20);
    idle(2);
    cyc(0, 0, 0, 1);
    chk("alarm_btn_exit", int'(state), 0);
    chk("alarm_btn_noclr", int'(clr), 0);
    repeat (3000) begin
      rc = $urandom_range(0, 199) == 0;
      rs = $urandom_range(0, 29) == 0;
      rm = $urandom_range(0, 29) == 0;
      ri = $urandom_range(0, 19) == 0;
      cyc(rc, rs, rm, ri);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/countdown_sequencer.md
Name: countdown_sequencer

Overview:
- Control FSM for the watch's countdown datapath (H:M:S down-counters with a zero flag).
- Turns debounced single-cycle button pulses into sequenced control strobes:
  - set-mode field increments;
  - start/pause/resume;
  - clear;
  - per-second decrement enables;
  - a timed alarm on expiry.
- Owns the 1 Hz time base, so the datapath never free-runs its own divider.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per second tick; minimum 4.
- ALARM_SECS, 10, seconds alarm stays asserted before auto-return to IDLE; range 1..255.
- TW, $clog2(TICK_DIV), width of the internal divider count.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- btn_start  in  1  start/pause toggle; one-cycle pulse.
- btn_mode  in  1  enter set mode / advance field; one-cycle pulse.
- btn_inc  in  1  increment selected field; one-cycle pulse.
- btn_clr  in  1  clear time to 00:00:00; one-cycle pulse.
- time_zero  in  1  datapath flag, high when H:M:S == 0; updates one cycle after any strobe.
- dec_en  out  1  one-cycle decrement-by-one-second strobe.
- inc_sec, inc_min, inc_hr  out  1 each  one-cycle field increment strobes; datapath wraps.
- clr  out  1  one-cycle clear strobe.
- alarm  out  1  high while in ALARM.
- state  out  3  current FSM state code.
- field  out  2  selected field: 0=SEC, 1=MIN, 2=HR.
- blink  out  1  display blink enable.

Behaviour:
- Reset values: all strobes 0, alarm=0, blink=0, state=IDLE, field=SEC, divider=0, alarm counter=0.
- All outputs are registered. A button pulse in cycle n gives its strobe or state change in cycle n+1.
- Button priority within one cycle: clr > start > mode > inc. Lower-priority pulses in the same cycle are dropped.
- Divider:
  - counts 0..TICK_DIV-1 only in RUN and ALARM;
  - holds its value in PAUSE;
  - clears on every entry to RUN from IDLE or SET, and on entry to ALARM;
  - "tick" is the cycle in which count == TICK_DIV-1.
- IDLE:
  - btn_start with time_zero=0 -> RUN; with time_zero=1 it is ignored.
  - btn_mode -> SET, field=SEC.
  - btn_clr -> clr pulse; stay in IDLE.
  - btn_inc ignored.
- SET:
  - btn_inc -> strobe for the current field (inc_sec/inc_min/inc_hr).
  - btn_mode advances SEC->MIN->HR; from HR it goes to IDLE with field=SEC.
  - btn_start with time_zero=0 -> RUN; with time_zero=1 it is ignored.
  - btn_clr -> clr pulse; stay in SET with field unchanged.
- RUN:
  - time_zero=1 has priority -> ALARM, and no dec_en is issued.
  - Otherwise, on tick -> dec_en pulse.
  - btn_start -> PAUSE.
  - btn_clr -> clr pulse and IDLE.
  - btn_mode and btn_inc ignored.
- PAUSE:
  - btn_start -> RUN, divider resumes from its held value with no clear.
  - btn_clr -> clr pulse and IDLE.
  - btn_mode and btn_inc ignored.
- ALARM:
  - alarm=1.
  - Alarm counter increments on each tick. When it reaches ALARM_SECS -> IDLE and the counter clears.
  - Any button pulse -> IDLE immediately, with no clr strobe.
- The alarm rising edge occurs one cycle after the dec_en that takes the datapath to zero, plus the one-cycle time_zero latency.
- Reset mid-operation returns everything to reset values immediately, independent of the clock.
- At most one strobe output is high in any cycle.
- State codes: IDLE=0, SET=1, RUN=2, PAUSE=3, ALARM=4.

Optional Feature:
- Macro: CDT_BLINK_EN.
- Defined:
  - blink toggles every TICK_DIV/2 cycles in SET and PAUSE, giving a 1 Hz square wave.
  - SET uses a free-running phase counter; PAUSE uses the held divider plus the phase counter.
  - blink forced to 0 in other states.
  - Phase counter clears on entry to SET.
- Undefined: blink tied to 0 and the phase counter is not synthesized.

Decomposition:
- Package cdt_pkg holds:
  - state enum (IDLE..ALARM);
  - field enum (SEC, MIN, HR);
  - default constants TICK_DIV_DEF and ALARM_SECS_DEF.
- Sub-module cdt_tick_gen: parameterised divider with inputs en and clr and output tick pulse (plus a half pulse under CDT_BLINK_EN).
- FSM, field register and alarm counter stay in the top module.

Test Plan (TICK_DIV=8, ALARM_SECS=3):
- Set mode: reset, then btn_mode, btn_inc x2, btn_mode, btn_inc -> inc_sec pulses twice, then inc_min once; field=1; state=SET.
- Countdown with pause: from IDLE with time_zero=0, btn_start -> RUN, dec_en every 8 cycles. btn_start mid-second -> PAUSE, no dec_en. Resume -> next dec_en arrives after the remaining cycles, not a full 8.
- Expiry: in RUN, model drives time_zero=1 one cycle after the final dec_en -> ALARM next cycle with alarm=1, no further dec_en. 24 cycles later -> IDLE, alarm=0.
- Zero start: btn_start in IDLE or SET with time_zero=1 -> state unchanged, no strobes.
- Simultaneous buttons: btn_clr and btn_start in the same cycle during RUN -> single clr pulse, state=IDLE, no PAUSE.
- Async reset: assert reset mid-ALARM between clock edges -> alarm=0, state=IDLE immediately. Then any button in ALARM -> IDLE without a clr strobe.
